// File: rtl/sobel_output_buffer.sv
// Sobel output buffer: captures each completed pixel (optionally binarized),
// queues it in a small FIFO and drains it over valid/ready, tracking a whole frame.
module sobel_output_buffer #(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned OUT_WIDTH   = 30,
    parameter int unsigned OUT_HEIGHT  = 30,
    localparam int unsigned FRAME_PIXELS = OUT_WIDTH * OUT_HEIGHT,
    localparam int unsigned CNT_W        = $clog2(FRAME_PIXELS + 1)
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic [PIXEL_WIDTH-1:0] pixel_i,
    input  logic                   pixel_completed_i,
    input  logic                   bin_en_i,
    input  logic [PIXEL_WIDTH-1:0] threshold_i,
    input  logic                   clear_i,
    output logic [PIXEL_WIDTH-1:0] out_data_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [CNT_W-1:0]       pixel_count_o,
    output logic                   overflow_o,
    output logic                   frame_done_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   prev_q, prev_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [PIXEL_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                   empty_c, full_c, pop_c, capture_c, push_c, drop_c;
    logic [PIXEL_WIDTH-1:0] cap_val_c;

    // FIFO status, handshake and capture decode
    always_comb begin
        empty_c   = (wr_ptr_q == rd_ptr_q);
        full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_c     = ~empty_c & out_ready_i;
        capture_c = pixel_completed_i & ~prev_q & (state_q == ST_COLLECT);
        push_c    = capture_c & (~full_c | pop_c) & ~clear_i;
        drop_c    = capture_c & full_c & ~pop_c;
        if (bin_en_i) begin
            cap_val_c = (pixel_i < threshold_i) ? '0 : '1;
        end else begin
            cap_val_c = pixel_i;
        end
    end

    // Next-state: pointers, frame count, sticky overflow and frame FSM
    always_comb begin
        state_d  = state_q;
        prev_d   = pixel_completed_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (clear_i) begin
            state_d  = ST_COLLECT;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (pop_c)     rd_ptr_d = rd_ptr_q + PW'(1);
            if (push_c)    wr_ptr_d = wr_ptr_q + PW'(1);
            if (capture_c) cnt_d    = cnt_q + CNT_W'(1);
            if (drop_c)    ovf_d    = 1'b1;
            case (state_q)
                ST_COLLECT: begin
                    if (capture_c && (cnt_q == CNT_W'(FRAME_PIXELS - 1))) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (wr_ptr_d == rd_ptr_d) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_COLLECT;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q  <= ST_COLLECT;
            prev_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= cap_val_c;
        end
    end

    // Outputs: first-word fall-through head and status
    always_comb begin
        out_data_o    = mem_q[rd_ptr_q[AW-1:0]];
        out_valid_o   = ~empty_c;
        pixel_count_o = cnt_q;
        overflow_o    = ovf_q;
        frame_done_o  = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_sobel_output_buffer.sv
// Scoreboard bench for sobel_output_buffer with a 3x3 output frame.
module tb_sobel_output_buffer;

    localparam int unsigned PW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned FRAME = 9;
    localparam int unsigned CW    = $clog2(FRAME + 1);

    logic          clk_i = 1'b0;
    logic          nreset_i = 1'b0;
    logic [PW-1:0] pixel_i = '0;
    logic          pixel_completed_i = 1'b0;
    logic          bin_en_i = 1'b0;
    logic [PW-1:0] threshold_i = '0;
    logic          clear_i = 1'b0;
    logic [PW-1:0] out_data_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [CW-1:0] pixel_count_o;
    logic          overflow_o;
    logic          frame_done_o;

    sobel_output_buffer #(
        .PIXEL_WIDTH(PW), .FIFO_DEPTH(DEPTH), .OUT_WIDTH(3), .OUT_HEIGHT(3)
    ) u_dut (
        .clk_i(clk_i), .nreset_i(nreset_i), .pixel_i(pixel_i),
        .pixel_completed_i(pixel_completed_i), .bin_en_i(bin_en_i),
        .threshold_i(threshold_i), .clear_i(clear_i), .out_data_o(out_data_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .pixel_count_o(pixel_count_o), .overflow_o(overflow_o),
        .frame_done_o(frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state (0=COLLECT, 1=DRAIN, 2=DONE)
    logic [PW-1:0] sb[$];
    logic [PW-1:0] out_log[$];
    logic          m_prev = 1'b0;
    int            m_state = 0;
    int            m_cnt = 0;
    logic          m_ovf = 1'b0;

    // Model update and output comparison, sampled on the falling edge
    always @(negedge clk_i) begin
        if (!nreset_i) begin
            sb.delete();
            m_prev = 1'b0; m_state = 0; m_cnt = 0; m_ovf = 1'b0;
            check("rst_valid", out_valid_o, 0);
            check("rst_count", pixel_count_o, 0);
            check("rst_ovf", overflow_o, 0);
            check("rst_done", frame_done_o, 0);
        end else begin
            int  size_before;
            logic pop, cap;
            logic [PW-1:0] val;
            check("valid", out_valid_o, (sb.size() > 0) ? 1 : 0);
            check("count", pixel_count_o, m_cnt);
            check("ovf", overflow_o, m_ovf);
            check("done", frame_done_o, (m_state == 2) ? 1 : 0);
            if (clear_i) begin
                sb.delete();
                m_state = 0; m_cnt = 0; m_ovf = 1'b0;
            end else begin
                size_before = sb.size();
                pop = (size_before > 0) && out_ready_i;
                if (pop) begin
                    check("data", out_data_o, sb[0]);
                    out_log.push_back(out_data_o);
                    void'(sb.pop_front());
                end
                cap = pixel_completed_i && !m_prev && (m_state == 0);
                if (cap) begin
                    if (bin_en_i) val = (pixel_i < threshold_i) ? 8'h00 : 8'hFF;
                    else          val = pixel_i;
                    m_cnt++;
                    if (size_before < DEPTH || pop) sb.push_back(val);
                    else                            m_ovf = 1'b1;
                    if (m_cnt == FRAME) m_state = 1;
                end else if (m_state == 1 && sb.size() == 0) begin
                    m_state = 2;
                end
            end
            m_prev = pixel_completed_i;
        end
    end

    task automatic step();
        @(posedge clk_i); #1;
    endtask

    task automatic cap_pix(input logic [PW-1:0] v, input int hold);
        step();
        pixel_i = v;
        pixel_completed_i = 1'b1;
        repeat (hold - 1) step();
        step();
        pixel_completed_i = 1'b0;
    endtask

    task automatic do_clear();
        step(); clear_i = 1'b1;
        step(); clear_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        out_ready_i = 1'b1;
        for (int i = 0; i < budget && (sb.size() > 0 || out_valid_o); i++) step();
        repeat (2) step();
        check("drained", out_valid_o, 0);
    endtask

    logic [PW-1:0] exp_bin [4];

    initial begin
        exp_bin[0] = 8'h00; exp_bin[1] = 8'hFF; exp_bin[2] = 8'h00; exp_bin[3] = 8'hFF;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_count", pixel_count_o, 0);
        check("reset_valid", out_valid_o, 0);
        nreset_i = 1'b1;

        // Basic pass-through with a 3-cycle completion pulse
        out_ready_i = 1'b1;
        out_log.delete();
        cap_pix(8'h5A, 3);
        repeat (3) step();
        check("pass_pops", out_log.size(), 1);
        if (out_log.size() > 0) check("pass_data", out_log[0], 8'h5A);
        check("pass_count", pixel_count_o, 1);

        // Binarization against 0x80
        do_clear();
        out_log.delete();
        bin_en_i = 1'b1; threshold_i = 8'h80;
        cap_pix(8'h7F, 1); cap_pix(8'h80, 1); cap_pix(8'h00, 1); cap_pix(8'hFF, 1);
        repeat (3) step();
        check("bin_pops", out_log.size(), 4);
        for (int i = 0; i < 4 && i < out_log.size(); i++) check("bin_data", out_log[i], exp_bin[i]);
        bin_en_i = 1'b0;

        // Full FIFO, overflow, frame end and ignored tenth capture
        do_clear();
        out_log.delete();
        out_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) cap_pix(PW'(8'h11 * (i + 1)), 2);
        step();
        check("full_valid", out_valid_o, 1);
        check("full_ovf", overflow_o, 1);
        check("full_count", pixel_count_o, 9);
        cap_pix(8'hEE, 1);
        step();
        check("ignored_count", pixel_count_o, 9);
        drain(40);
        check("ovf_pops", out_log.size(), 8);
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            check("ovf_data", out_log[i], PW'(8'h11 * (i + 1)));
        check("frame_done", frame_done_o, 1);

        // Clear while DONE
        do_clear();
        check("clr_done", frame_done_o, 0);
        check("clr_count", pixel_count_o, 0);
        check("clr_ovf", overflow_o, 0);

        // Simultaneous push and pop while full
        out_log.delete();
        out_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) cap_pix(PW'(8'hA0 + i), 1);
        step();
        pixel_i = 8'h33; pixel_completed_i = 1'b1; out_ready_i = 1'b1;
        step();
        pixel_completed_i = 1'b0;
        check("pp_ovf", overflow_o, 0);
        drain(40);
        check("pp_pops", out_log.size(), 9);
        if (out_log.size() == 9) begin
            check("pp_first", out_log[0], 8'hA0);
            check("pp_last", out_log[8], 8'h33);
        end
        check("pp_done", frame_done_o, 1);

        // Clear coinciding with a capture, flag held high across the clear
        do_clear();
        out_log.delete();
        out_ready_i = 1'b0;
        cap_pix(8'h01, 1); cap_pix(8'h02, 1);
        step();
        clear_i = 1'b1; pixel_i = 8'h77; pixel_completed_i = 1'b1;
        step();
        clear_i = 1'b0;
        step();
        pixel_completed_i = 1'b0;
        check("cc_count", pixel_count_o, 0);
        check("cc_valid", out_valid_o, 0);
        cap_pix(8'h12, 1);
        drain(20);
        check("cc_pops", out_log.size(), 1);
        if (out_log.size() > 0) check("cc_data", out_log[0], 8'h12);

        // Asynchronous reset mid-frame
        out_ready_i = 1'b0;
        cap_pix(8'h21, 1); cap_pix(8'h22, 1); cap_pix(8'h23, 1);
        step();
        #2 nreset_i = 1'b0;
        #1;
        check("arst_valid", out_valid_o, 0);
        check("arst_count", pixel_count_o, 0);
        check("arst_ovf", overflow_o, 0);
        check("arst_done", frame_done_o, 0);
        step();
        nreset_i = 1'b1;
        out_log.delete();
        cap_pix(8'h44, 1);
        drain(20);
        check("post_rst_pops", out_log.size(), 1);
        check("post_rst_count", pixel_count_o, 1);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time guard
    initial begin
        #200000;
        $display("FAIL timeout: got sim time %0t expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
